load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, giving the address width in bits.
REQ-002 The block SHALL have parameter TIMEOUT, default 15, giving the maximum number of mem_ready_i wait cycles before a bus error; 0 disables the timeout.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset: clk_i  input  1  clock, all state on rising edge.
REQ-004 rst_i  input  1  asynchronous active-high reset.
REQ-005 req_valid_i  input  1  request present.
REQ-006 req_ready_o  output  1  request accepted this cycle when high together with req_valid_i.
REQ-007 req_we_i  input  1  1 = store, 0 = load.
REQ-008 req_funct3_i  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 req_addr_i  input  ADDR_W  byte address.
REQ-010 req_wdata_i  input  32  store data, right-aligned.
REQ-011 mem_en_o  output  1  memory access strobe.
REQ-012 mem_we_o  output  4  byte write enables, with bit n for byte lane n.
REQ-013 mem_addr_o  output  ADDR_W  word address: req_addr_i with bits [1:0] forced to 0.
REQ-014 mem_wdata_o  output  32  lane-replicated store data.
REQ-015 mem_rdata_i  input  32  memory read word.
REQ-016 mem_ready_i  input  1  memory completes the access this cycle.
REQ-017 rsp_valid_o  output  1  one-cycle response pulse.
REQ-018 rsp_rdata_o  output  32  extended load data, or 0 for stores and errors.
REQ-019 rsp_err_o  output  2  00 ok, 01 misaligned, 10 timeout, 11 illegal funct3.
REQ-020 busy_o  output  1  high in any state other than IDLE.

Function
REQ-021 The FSM SHALL have the states IDLE, ACCESS and RESP; req_ready_o SHALL be high only in IDLE.
REQ-022 On accept, the block SHALL register we, funct3, addr and wdata, and SHALL ignore req_* inputs until the FSM returns to IDLE.
REQ-023 Legality: a load SHALL use funct3 in {000,001,010,100,101} and a store SHALL use funct3 in {000,001,010}; any other code SHALL go IDLE->RESP with err=11.
REQ-024 Alignment: H/HU with addr[0]=1, or W with addr[1:0]!=00, SHALL go IDLE->RESP with err=01; illegal funct3 SHALL take priority over misalignment.
REQ-025 On any accept error, mem_en_o SHALL never assert for that request.
REQ-026 A legal, aligned accept SHALL go to ACCESS; in ACCESS, mem_en_o, mem_addr_o, mem_we_o and mem_wdata_o SHALL be held stable until the FSM leaves ACCESS.
REQ-027 Store enables SHALL be: SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],1'b0}; SW 4'b1111. Loads SHALL drive mem_we_o=0000.
REQ-028 Store data SHALL be: SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
REQ-029 Load extraction SHALL take the byte at lane addr[1:0] or the halfword at lane addr[1]; B/H SHALL sign-extend, BU/HU SHALL zero-extend, and W SHALL pass the word.
REQ-030 mem_ready_i sampled high in ACCESS SHALL capture the response data (REQ-029; 0 for a store), set err=00 and go to RESP.
REQ-031 A wait counter SHALL clear on entry to ACCESS and SHALL increment each ACCESS cycle in which mem_ready_i is low.
REQ-032 When TIMEOUT>0 and the counter equals TIMEOUT with mem_ready_i low, the FSM SHALL go to RESP with err=10 and rsp_rdata_o=0.
REQ-033 The counter width SHALL be clog2(TIMEOUT+1), minimum 1, and the counter SHALL NOT wrap.
REQ-034 mem_ready_i high on the timeout cycle SHALL win, so the access completes with err=00.
REQ-035 In RESP, rsp_valid_o SHALL be high for exactly one cycle, after which the FSM SHALL return to IDLE.
REQ-036 rsp_rdata_o and rsp_err_o SHALL be valid with rsp_valid_o and SHALL hold their value until the next response.
REQ-037 Latency SHALL be: rsp_valid_o one cycle after the mem_ready_i sample, or one cycle after accept on error; the minimum request spacing SHALL be 3 cycles.
REQ-038 mem_ready_i outside ACCESS SHALL be ignored.

Reset
REQ-039 rst_i high SHALL immediately force IDLE, clear the counter, and drive rsp_valid_o, mem_en_o, mem_we_o and busy_o to 0.
REQ-040 While rst_i is high, rsp_rdata_o, rsp_err_o, mem_addr_o and mem_wdata_o SHALL be 0 and req_ready_o SHALL be 0.
REQ-041 On reset release, req_ready_o SHALL be 1 from the first clock edge.
REQ-042 A reset asserted in ACCESS or RESP SHALL abort the access with no response pulse.

Verification
REQ-043 SB addr=0x103, wdata=0x000000A5, ready same cycle -> mem_we_o=1000, mem_wdata_o=0xA5A5A5A5, mem_addr_o=0x100, rsp_valid_o 1 cycle later, err=00.
REQ-044 LB addr=0x22 with mem_rdata_i=0x12F0_5678 -> rsp_rdata_o=0xFFFFFFF0; the same access as LBU -> 0x000000F0; as LHU at 0x22 -> 0x000012F0.
REQ-045 LW addr=0x6 -> err=01, mem_en_o never high, rsp_valid_o on the cycle after accept; SW with funct3=100 -> err=11.
REQ-046 TIMEOUT=3 with mem_ready_i held low -> mem_en_o high for 4 cycles, then rsp_valid_o with err=10; mem_ready_i high on the 4th ACCESS cycle -> err=00.
REQ-047 rst_i pulsed in the 2nd ACCESS cycle -> mem_en_o low without waiting for a clock edge, no rsp_valid_o, req_ready_o=1 after release.
REQ-048 Back-to-back requests with req_valid_i held high and ready every cycle -> accepts exactly every 3 cycles and one response per accept.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I-style load/store front end for a single-port word memory.
// Checks width code and alignment, drives a byte-lane memory access, extracts and
// extends load data, and returns one response pulse per accepted request.
//
// Ports:
//   clk_i, rst_i        clock (rising edge), asynchronous active-high reset
//   req_valid_i/ready_o request handshake; ready only while idle
//   req_we_i            1 = store, 0 = load
//   req_funct3_i        width code: B, H, W, BU, HU
//   req_addr_i          byte address
//   req_wdata_i         right-aligned store data
//   mem_en_o            memory access strobe, held for the whole access
//   mem_we_o            per-lane byte write enables
//   mem_addr_o          word-aligned address
//   mem_wdata_o         lane-replicated store data
//   mem_rdata_i         memory read word
//   mem_ready_i         memory completes the access this cycle
//   rsp_valid_o         one-cycle response pulse
//   rsp_rdata_o         extended load data (0 for stores and errors)
//   rsp_err_o           00 ok, 01 misaligned, 10 timeout, 11 illegal funct3
//   busy_o              high whenever not idle
module load_store_unit #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              mem_en_o,
    output logic [3:0]        mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    input  logic              mem_ready_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_rdata_o,
    output logic [1:0]        rsp_err_o,
    output logic              busy_o
);

    localparam int unsigned CNT_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit          TIMEOUT_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } stateT;

    stateT            state;
    logic [CNT_W-1:0] waitCnt;
    logic             weQ;
    logic [2:0]       funct3Q;
    logic [1:0]       addrLowQ;

    logic             isIllegal;
    logic             isMisaligned;
    logic [3:0]       storeWe;
    logic [31:0]      storeData;
    logic [7:0]       laneByte;
    logic [15:0]      laneHalf;
    logic [31:0]      loadData;
    logic             accept;
    logic             timedOut;

    assign accept   = req_valid_i && req_ready_o;
    // The ready sample has priority, so a timeout only fires with mem_ready_i low.
    assign timedOut = TIMEOUT_EN && (waitCnt == CNT_W'(TIMEOUT));

    // Request decode: legality, alignment, byte enables and lane-replicated data.
    always_comb begin
        isIllegal    = 1'b0;
        isMisaligned = 1'b0;
        storeWe      = 4'b0000;
        storeData    = req_wdata_i;
        case (req_funct3_i)
            3'b000: begin
                storeWe   = 4'b0001 << req_addr_i[1:0];
                storeData = {4{req_wdata_i[7:0]}};
            end
            3'b001: begin
                isMisaligned = req_addr_i[0];
                storeWe      = 4'b0011 << {req_addr_i[1], 1'b0};
                storeData    = {2{req_wdata_i[15:0]}};
            end
            3'b010: begin
                isMisaligned = (req_addr_i[1:0] != 2'b00);
                storeWe      = 4'b1111;
            end
            3'b100: isIllegal = req_we_i;
            3'b101: begin
                isIllegal    = req_we_i;
                isMisaligned = req_addr_i[0];
            end
            default: isIllegal = 1'b1;
        endcase
    end

    // Load extraction from the registered lane offset and width code.
    always_comb begin
        laneByte = mem_rdata_i[7:0];
        case (addrLowQ)
            2'd0: laneByte = mem_rdata_i[7:0];
            2'd1: laneByte = mem_rdata_i[15:8];
            2'd2: laneByte = mem_rdata_i[23:16];
            2'd3: laneByte = mem_rdata_i[31:24];
            default: laneByte = mem_rdata_i[7:0];
        endcase
        laneHalf = addrLowQ[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (funct3Q)
            3'b000:  loadData = {{24{laneByte[7]}}, laneByte};
            3'b001:  loadData = {{16{laneHalf[15]}}, laneHalf};
            3'b100:  loadData = {24'd0, laneByte};
            3'b101:  loadData = {16'd0, laneHalf};
            default: loadData = mem_rdata_i;
        endcase
        if (weQ) begin
            loadData = 32'd0;
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            waitCnt     <= '0;
            weQ         <= 1'b0;
            funct3Q     <= 3'b000;
            addrLowQ    <= 2'b00;
            req_ready_o <= 1'b0;
            mem_en_o    <= 1'b0;
            mem_we_o    <= 4'b0000;
            mem_addr_o  <= '0;
            mem_wdata_o <= 32'd0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= 32'd0;
            rsp_err_o   <= 2'b00;
            busy_o      <= 1'b0;
        end else begin
            rsp_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        weQ         <= req_we_i;
                        funct3Q     <= req_funct3_i;
                        addrLowQ    <= req_addr_i[1:0];
                        req_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        if (isIllegal || isMisaligned) begin
                            // Illegal width code outranks misalignment; no memory access.
                            state       <= RESP;
                            rsp_valid_o <= 1'b1;
                            rsp_rdata_o <= 32'd0;
                            rsp_err_o   <= isIllegal ? 2'b11 : 2'b01;
                        end else begin
                            state       <= ACCESS;
                            waitCnt     <= '0;
                            mem_en_o    <= 1'b1;
                            mem_we_o    <= req_we_i ? storeWe : 4'b0000;
                            mem_addr_o  <= {req_addr_i[ADDR_W-1:2], 2'b00};
                            mem_wdata_o <= storeData;
                        end
                    end else begin
                        req_ready_o <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (mem_ready_i || timedOut) begin
                        state       <= RESP;
                        mem_en_o    <= 1'b0;
                        mem_we_o    <= 4'b0000;
                        rsp_valid_o <= 1'b1;
                        rsp_rdata_o <= mem_ready_i ? loadData : 32'd0;
                        rsp_err_o   <= mem_ready_i ? 2'b00 : 2'b10;
                    end else if (waitCnt != {CNT_W{1'b1}}) begin
                        // Saturate rather than wrap when the timeout is disabled.
                        waitCnt <= waitCnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    state       <= IDLE;
                    req_ready_o <= 1'b1;
                    busy_o      <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    req_ready_o <= 1'b1;
                    busy_o      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (TIMEOUT=3) with a response scoreboard.
module tb_load_store_unit;

    localparam int unsigned ADDR_W = 32;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_we_i;
    logic [2:0]        req_funct3_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [31:0]       req_wdata_i;
    logic              mem_en_o;
    logic [3:0]        mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic [31:0]       mem_rdata_i;
    logic              mem_ready_i;
    logic              rsp_valid_o;
    logic [31:0]       rsp_rdata_o;
    logic [1:0]        rsp_err_o;
    logic              busy_o;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  err;
    } rspT;

    rspT sbQ[$];
    int  checks   = 0;
    int  failures = 0;
    int  enCycles = 0;

    load_store_unit #(.ADDR_W(ADDR_W), .TIMEOUT(3)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_funct3_i (req_funct3_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .mem_en_o     (mem_en_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_ready_i  (mem_ready_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Response scoreboard and strobe counter, sampled on the falling edge.
    always @(negedge clk_i) begin
        if (mem_en_o) enCycles++;
        if (rsp_valid_o) begin
            if (sbQ.size() == 0) begin
                check("unexpected_rsp", 32'(rsp_valid_o), 32'd0);
            end else begin
                rspT e;
                e = sbQ.pop_front();
                check("rsp_rdata", rsp_rdata_o, e.rdata);
                check("rsp_err", 32'(rsp_err_o), 32'(e.err));
            end
        end
    end

    task automatic waitIdle();
        int i;
        for (i = 0; i < 20 && !(sbQ.size() == 0 && req_ready_o === 1'b1); i++) @(negedge clk_i);
        check("drain_pending", 32'(sbQ.size()), 32'd0);
        check("drain_ready", 32'(req_ready_o), 32'd1);
    endtask

    task automatic sendReq(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
        check("req_ready", 32'(req_ready_o), 32'd1);
        req_valid_i  = 1'b1;
        req_we_i     = we;
        req_funct3_i = f3;
        req_addr_i   = addr;
        req_wdata_i  = wdata;
        @(negedge clk_i);
        req_valid_i  = 1'b0;
        req_we_i     = 1'($urandom);
        req_funct3_i = 3'($urandom);
        req_addr_i   = $urandom;
        req_wdata_i  = $urandom;
    endtask

    task automatic serve(input logic [31:0] rdata, input int lowCycles);
        for (int i = 0; i < lowCycles; i++) begin
            check("wait_mem_en", 32'(mem_en_o), 32'd1);
            @(negedge clk_i);
        end
        mem_ready_i = 1'b1;
        mem_rdata_i = rdata;
        @(negedge clk_i);
        mem_ready_i = 1'b0;
        mem_rdata_i = $urandom;
    endtask

    task automatic doLoad(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata, input logic [31:0] expData);
        sbQ.push_back('{rdata: expData, err: 2'b00});
        sendReq(1'b0, f3, addr, 32'hFFFF_FFFF);
        check("ld_mem_en", 32'(mem_en_o), 32'd1);
        check("ld_mem_we", 32'(mem_we_o), 32'd0);
        check("ld_mem_addr", mem_addr_o, addr & 32'hFFFF_FFFC);
        serve(rdata, 0);
        waitIdle();
    endtask

    task automatic doStore(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] expWe, input logic [31:0] expWdata);
        sbQ.push_back('{rdata: 32'd0, err: 2'b00});
        sendReq(1'b1, f3, addr, wdata);
        check("st_mem_en", 32'(mem_en_o), 32'd1);
        check("st_mem_we", 32'(mem_we_o), 32'(expWe));
        check("st_mem_addr", mem_addr_o, addr & 32'hFFFF_FFFC);
        check("st_mem_wdata", mem_wdata_o, expWdata);
        check("st_busy", 32'(busy_o), 32'd1);
        serve(32'h5555_AAAA, 0);
        waitIdle();
    endtask

    task automatic doErr(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [1:0] expErr);
        enCycles = 0;
        sbQ.push_back('{rdata: 32'd0, err: expErr});
        sendReq(we, f3, addr, 32'h1234_5678);
        check("err_rsp_valid", 32'(rsp_valid_o), 32'd1);
        check("err_mem_en", 32'(mem_en_o), 32'd0);
        waitIdle();
        check("err_en_cycles", 32'(enCycles), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepts;
        int lastAcc;
        rst_i        = 1'b1;
        req_valid_i  = 1'b0;
        req_we_i     = 1'b0;
        req_funct3_i = 3'b000;
        req_addr_i   = '0;
        req_wdata_i  = 32'd0;
        mem_rdata_i  = 32'd0;
        mem_ready_i  = 1'b0;

        // Outputs while reset is held.
        repeat (2) @(negedge clk_i);
        check("rst_req_ready", 32'(req_ready_o), 32'd0);
        check("rst_mem_en", 32'(mem_en_o), 32'd0);
        check("rst_mem_we", 32'(mem_we_o), 32'd0);
        check("rst_mem_addr", mem_addr_o, 32'd0);
        check("rst_mem_wdata", mem_wdata_o, 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_rsp_rdata", rsp_rdata_o, 32'd0);
        check("rst_rsp_err", 32'(rsp_err_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("post_rst_ready", 32'(req_ready_o), 32'd1);

        // Stores: byte, halfword, word.
        doStore(3'b000, 32'h0000_0103, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5);
        doStore(3'b000, 32'h0000_0011, 32'h0000_003C, 4'b0010, 32'h3C3C_3C3C);
        doStore(3'b001, 32'h0000_0002, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD);
        doStore(3'b001, 32'h0000_0004, 32'h0000_8001, 4'b0011, 32'h8001_8001);
        doStore(3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);

        // Loads with sign and zero extension.
        doLoad(3'b000, 32'h0000_0022, 32'h12F0_5678, 32'hFFFF_FFF0);
        check("rsp_hold", rsp_rdata_o, 32'hFFFF_FFF0);
        doLoad(3'b100, 32'h0000_0022, 32'h12F0_5678, 32'h0000_00F0);
        doLoad(3'b101, 32'h0000_0022, 32'h12F0_5678, 32'h0000_12F0);
        doLoad(3'b001, 32'h0000_0020, 32'h12F0_8678, 32'hFFFF_8678);
        doLoad(3'b101, 32'h0000_0020, 32'h12F0_8678, 32'h0000_8678);
        doLoad(3'b000, 32'h0000_0021, 32'h12F0_5678, 32'h0000_0056);
        doLoad(3'b010, 32'h0000_0020, 32'hCAFE_F00D, 32'hCAFE_F00D);

        // Accept-time errors.
        doErr(1'b0, 3'b010, 32'h0000_0006, 2'b01);
        doErr(1'b0, 3'b001, 32'h0000_0003, 2'b01);
        doErr(1'b1, 3'b100, 32'h0000_0000, 2'b11);
        doErr(1'b1, 3'b101, 32'h0000_0000, 2'b11);
        doErr(1'b0, 3'b011, 32'h0000_0001, 2'b11);
        doErr(1'b0, 3'b110, 32'h0000_0003, 2'b11);

        // Timeout with ready held low.
        enCycles = 0;
        sbQ.push_back('{rdata: 32'd0, err: 2'b10});
        sendReq(1'b0, 3'b010, 32'h0000_0040, 32'd0);
        waitIdle();
        check("to_en_cycles", 32'(enCycles), 32'd4);

        // Ready on the last allowed wait cycle wins over the timeout.
        enCycles = 0;
        sbQ.push_back('{rdata: 32'h0BAD_F00D, err: 2'b00});
        sendReq(1'b0, 3'b010, 32'h0000_0044, 32'd0);
        serve(32'h0BAD_F00D, 3);
        waitIdle();
        check("late_en_cycles", 32'(enCycles), 32'd4);

        // Reset during the second access cycle aborts silently.
        sendReq(1'b0, 3'b010, 32'h0000_0080, 32'd0);
        @(negedge clk_i);
        check("abort_mem_en_pre", 32'(mem_en_o), 32'd1);
        rst_i = 1'b1;
        #1;
        check("abort_mem_en", 32'(mem_en_o), 32'd0);
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("abort_req_ready", 32'(req_ready_o), 32'd0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("abort_post_ready", 32'(req_ready_o), 32'd1);
        check("abort_post_busy", 32'(busy_o), 32'd0);

        // Back-to-back loads with ready held high throughout.
        mem_ready_i  = 1'b1;
        mem_rdata_i  = 32'hCAFE_F00D;
        req_valid_i  = 1'b1;
        req_we_i     = 1'b0;
        req_funct3_i = 3'b010;
        req_addr_i   = 32'h0000_0100;
        req_wdata_i  = 32'd0;
        accepts = 0;
        lastAcc = -1;
        for (int c = 0; c < 12; c++) begin
            if (req_ready_o) begin
                if (lastAcc >= 0) check("b2b_spacing", 32'(c - lastAcc), 32'd3);
                sbQ.push_back('{rdata: 32'hCAFE_F00D, err: 2'b00});
                accepts++;
                lastAcc = c;
            end
            @(negedge clk_i);
        end
        req_valid_i = 1'b0;
        waitIdle();
        mem_ready_i = 1'b0;
        check("b2b_accepts", 32'(accepts), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
